// File: rtl/mem_wb.sv
// rtl/mem_wb.sv - MEM/WB pipeline register with stall, flush and optional retire counter (MEM_WB_RETIRE_CNT_EN)
module mem_wb (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_whilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic [31:0] retire_cnt,
`endif
  output logic        wb_valid,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_whilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo
);

  // Only the MEM and WB bits of the global stall vector matter here.
  logic mem_stall;
  logic wb_stall;
  logic load_bubble;
  logic advance;
  logic unused_stall;

  assign mem_stall    = stall[4];
  assign wb_stall     = stall[5];
  assign unused_stall = ^stall[3:0];

  // Flush wins over everything; MEM held with WB free inserts a bubble.
  // Any other stalled combination (including the illegal WB-only stall) holds.
  assign load_bubble = flush || (mem_stall && !wb_stall);
  assign advance     = !flush && !mem_stall && !wb_stall;

  // Pipeline register: bubble, hold or advance; write enables gated by the valid bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_wd    <= 5'h00;
      wb_wreg  <= 1'b0;
      wb_wdata <= 32'h0;
      wb_whilo <= 1'b0;
      wb_hi    <= 32'h0;
      wb_lo    <= 32'h0;
    end else if (load_bubble) begin
      wb_valid <= 1'b0;
      wb_wd    <= 5'h00;
      wb_wreg  <= 1'b0;
      wb_wdata <= 32'h0;
      wb_whilo <= 1'b0;
      wb_hi    <= 32'h0;
      wb_lo    <= 32'h0;
    end else if (advance) begin
      wb_valid <= mem_valid;
      wb_wd    <= mem_wd;
      wb_wreg  <= mem_wreg && mem_valid;
      wb_wdata <= mem_wdata;
      wb_whilo <= mem_whilo && mem_valid;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end

`ifdef MEM_WB_RETIRE_CNT_EN
  // Count real instructions entering WB; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= 32'h0;
    end else if (advance && mem_valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // A WB stall without a MEM stall means the stall controller is broken.
  stall_monotonic_a: assert property (@(posedge clk) disable iff (!rst) !(wb_stall && !mem_stall))
    else $error("mem_wb: illegal stall vector %b", stall);
`endif

endmodule
